tag_allocator: RTL and testbench

TAG_ALLOCATOR -- requirements
Module: tag_allocator

---
 rtl/tag_allocator_pkg.sv | 24 ++
 rtl/tag_alloc_ffs.sv | 24 ++
 rtl/tag_allocator.sv | 109 ++++++++++
 tb/tb_tag_allocator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_allocator_pkg.sv
// Shared constants and types for the tag allocator: tag width, default reserved
// tags, error encodings and flush state machine states.
package tag_allocator_pkg;

   localparam int unsigned TAG_W    = 5;
   localparam int unsigned NUM_TAGS = 1 << TAG_W;

   // Tags 0 and 0x10 are never handed out.
   localparam logic [NUM_TAGS-1:0] DEFAULT_RESERVED_MASK = 32'h0001_0001;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_RESERVED = 2'd1,
      ERR_DOUBLE   = 2'd2,
      ERR_EMPTY    = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } alloc_state_e;

endpackage : tag_allocator_pkg

// File: rtl/tag_alloc_ffs.sv
// Find-first-set: returns the index of the lowest set bit of a 32-bit vector,
// with a found flag; the index is 0 when no bit is set.
module tag_alloc_ffs
   import tag_allocator_pkg::*;
(
   input  logic [NUM_TAGS-1:0] vec_i,
   output logic [TAG_W-1:0]    idx_o,
   output logic                found_o
);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      // Scan downwards so the last hit, and therefore the winner, is the lowest index.
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o   = TAG_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule : tag_alloc_ffs

// File: rtl/tag_allocator.sv
// Tag allocator: hands out the lowest free unreserved tag, accepts returns,
// flags protocol errors and supports a flush/drain handshake.
module tag_allocator
   import tag_allocator_pkg::*;
#(
   parameter logic [NUM_TAGS-1:0] RESERVED_MASK   = DEFAULT_RESERVED_MASK,
   parameter int unsigned         MAX_OUTSTANDING = 30
) (
   input  logic             clock,
   input  logic             reset,
   output logic             alloc_valid,
   input  logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             free_valid,
   input  logic [TAG_W-1:0] free_tag,
   input  logic             flush_req,
   output logic             flush_done,
   output logic [TAG_W-1:0] outstanding,
   output logic             err_valid,
   output logic [1:0]       err_code
);

   logic [NUM_TAGS-1:0] bitmap_q, bitmap_d;
   logic [TAG_W-1:0]    count_q, count_d;
   alloc_state_e        state_q, state_d;
   logic                err_valid_q, err_valid_d;
   err_code_e           err_code_q, err_code_d;

   logic                tag_found;
   logic                fire;
   logic                free_ok;
   err_code_e           free_err;

   tag_alloc_ffs u_ffs (
      .vec_i   (~bitmap_q & ~RESERVED_MASK),
      .idx_o   (alloc_tag),
      .found_o (tag_found)
   );

   assign alloc_valid = (state_q == ST_RUN) && tag_found &&
                        (32'(count_q) < MAX_OUTSTANDING);
   assign fire        = alloc_valid & alloc_ready;

   // A tag being allocated on this very edge is not yet in use, so returning it
   // is a double free even when nothing else is outstanding.
   always_comb begin
      free_err = ERR_NONE;
      if (free_valid) begin
         if (RESERVED_MASK[free_tag])                 free_err = ERR_RESERVED;
         else if (fire && (free_tag == alloc_tag))    free_err = ERR_DOUBLE;
         else if (count_q == '0)                      free_err = ERR_EMPTY;
         else if (!bitmap_q[free_tag])                free_err = ERR_DOUBLE;
      end
   end

   assign free_ok = free_valid && (free_err == ERR_NONE);

   always_comb begin
      bitmap_d = bitmap_q;
      if (fire)    bitmap_d[alloc_tag] = 1'b1;
      if (free_ok) bitmap_d[free_tag]  = 1'b0;
      bitmap_d = bitmap_d & ~RESERVED_MASK;

      count_d = count_q;
      unique case ({fire, free_ok})
         2'b10:   count_d = count_q + TAG_W'(1);
         2'b01:   count_d = count_q - TAG_W'(1);
         default: count_d = count_q;
      endcase

      err_valid_d = err_valid_q || (free_err != ERR_NONE);
      err_code_d  = err_code_q;
      if (!err_valid_q && (free_err != ERR_NONE)) err_code_d = free_err;
   end

   // Drain completion looks at the post-update count so a same-edge free counts.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:   if (flush_req)         state_d = ST_DRAIN;
         ST_DRAIN: if (count_d == '0)     state_d = ST_DONE;
         ST_DONE:  if (!flush_req)        state_d = ST_RUN;
         default:                         state_d = ST_RUN;
      endcase
   end

   // NOTE: registers update with non-blocking assignments; reset clears every bit of state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bitmap_q    <= '0;
         count_q     <= '0;
         state_q     <= ST_RUN;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         bitmap_q    <= bitmap_d;
         count_q     <= count_d;
         state_q     <= state_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign flush_done  = (state_q == ST_DONE);
   assign outstanding = count_q;
   assign err_valid   = err_valid_q;
   assign err_code    = err_code_q;

endmodule : tag_allocator

// File: tb/tb_tag_allocator.sv
// Testbench for tag_allocator: directed scenarios plus random traffic, all
// checked cycle by cycle against a tag-set reference model.
module tb_tag_allocator;

   localparam logic [31:0] RSV  = 32'h0001_0001;
   localparam int          MAXO = 30;

   logic       clock = 1'b0;
   logic       reset;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [4:0] alloc_tag;
   logic       free_valid;
   logic [4:0] free_tag;
   logic       flush_req;
   logic       flush_done;
   logic [4:0] outstanding;
   logic       err_valid;
   logic [1:0] err_code;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: set of tags held by the consumer, count, flush phase, error latch.
   bit m_use [32];
   int m_cnt;
   int m_phase;   // 0 running, 1 draining, 2 drained
   bit m_errv;
   int m_errc;

   tag_allocator #(
      .RESERVED_MASK   (RSV),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .alloc_valid (alloc_valid),
      .alloc_ready (alloc_ready),
      .alloc_tag   (alloc_tag),
      .free_valid  (free_valid),
      .free_tag    (free_tag),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .outstanding (outstanding),
      .err_valid   (err_valid),
      .err_code    (err_code)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic int lowest_free();
      for (int t = 0; t < 32; t++)
         if (!RSV[t] && !m_use[t]) return t;
      return -1;
   endfunction

   function automatic bit exp_valid();
      return (m_phase == 0) && (lowest_free() >= 0) && (m_cnt < MAXO);
   endfunction

   task automatic model_reset();
      foreach (m_use[t]) m_use[t] = 1'b0;
      m_cnt   = 0;
      m_phase = 0;
      m_errv  = 1'b0;
      m_errc  = 0;
   endtask

   task automatic check_outputs();
      bit ev;
      ev = exp_valid();
      check("alloc_valid", 32'(alloc_valid), 32'(ev));
      if (ev) check("alloc_tag", 32'(alloc_tag), 32'(lowest_free()));
      check("flush_done", 32'(flush_done), 32'(m_phase == 2));
      check("outstanding", 32'(outstanding), 32'(m_cnt));
      check("err_valid", 32'(err_valid), 32'(m_errv));
      check("err_code", 32'(err_code), 32'(m_errc));
   endtask

   task automatic model_update();
      bit fire;
      int atag;
      int code;
      fire = exp_valid() && alloc_ready;
      atag = lowest_free();
      code = 0;
      if (free_valid) begin
         if (RSV[free_tag])                       code = 1;
         else if (fire && int'(free_tag) == atag) code = 2;
         else if (m_cnt == 0)                     code = 3;
         else if (!m_use[free_tag])               code = 2;
      end
      if (fire) begin
         m_use[atag] = 1'b1;
         m_cnt++;
      end
      if (free_valid && code == 0) begin
         m_use[free_tag] = 1'b0;
         m_cnt--;
      end
      if (code != 0) begin
         if (!m_errv) m_errc = code;
         m_errv = 1'b1;
      end
      case (m_phase)
         0: if (flush_req) m_phase = 1;
         1: if (m_cnt == 0) m_phase = 2;
         default: if (!flush_req) m_phase = 0;
      endcase
   endtask

   // Check current outputs, advance the model with the current inputs, clock once.
   task automatic step();
      check_outputs();
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_ready = 1'b0;
      free_valid  = 1'b0;
      free_tag    = '0;
      flush_req   = 1'b0;
   endtask

   // Assert reset asynchronously, check the cleared state at once, release after an edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      check("rst_alloc_tag", 32'(alloc_tag), 32'd1);
      idle_inputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check_outputs();
   endtask

   function automatic int pick_free_tag();
      int held [$];
      for (int t = 0; t < 32; t++) if (m_use[t]) held.push_back(t);
      if (held.size() > 0 && $urandom_range(0, 9) < 8)
         return held[$urandom_range(0, held.size() - 1)];
      return int'($urandom_range(0, 31));
   endfunction

   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      do_reset();

      // Fill every unreserved tag in ascending order, skipping 0 and 16.
      alloc_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         check("fill_order", 32'(alloc_tag), 32'(i < 15 ? i + 1 : i + 2));
         step();
      end
      alloc_ready = 1'b0;
      check("full_valid", 32'(alloc_valid), 32'd0);
      check("full_count", 32'(outstanding), 32'd30);
      step();

      // Simultaneous allocate and free.
      do_reset();
      alloc_ready = 1'b1;
      repeat (3) step();
      free_valid = 1'b1;
      free_tag   = 5'd2;
      check("simul_tag", 32'(alloc_tag), 32'd4);
      step();
      alloc_ready = 1'b0;
      free_valid  = 1'b0;
      check("simul_count", 32'(outstanding), 32'd3);
      check("simul_reoffer", 32'(alloc_tag), 32'd2);

      // Reserved-tag free, then a second error that must not overwrite the code.
      free_valid = 1'b1;
      free_tag   = 5'd16;
      step();
      free_valid = 1'b0;
      check("rsv_err_valid", 32'(err_valid), 32'd1);
      check("rsv_err_code", 32'(err_code), 32'd1);
      check("rsv_count", 32'(outstanding), 32'd3);
      free_valid = 1'b1;
      free_tag   = 5'd9;
      step();
      free_valid = 1'b0;
      check("sticky_code", 32'(err_code), 32'd1);
      check("sticky_tag", 32'(alloc_tag), 32'd2);

      // Stall: offered tag stays put while the consumer is not ready.
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_tag", 32'(alloc_tag), 32'd2);
         check("stall_count", 32'(outstanding), 32'd3);
      end

      // Flush with two outstanding tags.
      do_reset();
      alloc_ready = 1'b1;
      repeat (2) step();
      alloc_ready = 1'b0;
      flush_req   = 1'b1;
      step();
      check("drain_valid", 32'(alloc_valid), 32'd0);
      free_valid = 1'b1;
      free_tag   = 5'd1;
      step();
      check("drain_not_done", 32'(flush_done), 32'd0);
      free_tag = 5'd2;
      step();
      free_valid = 1'b0;
      check("flush_done", 32'(flush_done), 32'd1);
      flush_req = 1'b0;
      step();
      check("resume_valid", 32'(alloc_valid), 32'd1);
      step();

      // Reset in the middle of a drain with five outstanding.
      do_reset();
      alloc_ready = 1'b1;
      repeat (5) step();
      alloc_ready = 1'b0;
      flush_req   = 1'b1;
      step();
      check("pre_rst_count", 32'(outstanding), 32'd5);
      do_reset();
      check("post_rst_valid", 32'(alloc_valid), 32'd1);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         alloc_ready = ($urandom_range(0, 9) < 6);
         free_valid  = ($urandom_range(0, 9) < 4);
         free_tag    = 5'(pick_free_tag());
         if ($urandom_range(0, 24) == 0) flush_req = ~flush_req;
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            step();
         end
      end
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_tag_allocator
